// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD reader and writer.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        SETUP,
        EHIGH,
        EHOLD,
        DONE
    } state_t;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;
    localparam int unsigned BF_BIT = 7;

    localparam int unsigned T_AS_DEF     = 3;
    localparam int unsigned E_HIGH_DEF   = 25;
    localparam int unsigned E_LOW_DEF    = 25;
    localparam int unsigned POLL_MAX_DEF = 100000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter timing one bus phase; done_c marks the phase's last cycle.
module lcd_phase_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         done_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len - W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done_c = (cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// Read-cycle controller for the HD44780 bus: busy-flag/address or data reads,
// with optional busy polling, behind a bus arbiter.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS     = T_AS_DEF,
    parameter int unsigned E_HIGH   = E_HIGH_DEF,
    parameter int unsigned E_LOW    = E_LOW_DEF,
    parameter int unsigned POLL_MAX = POLL_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       bus_req,
    input  logic       bus_gnt,
    input  logic [7:0] lcd_data_i,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    localparam int unsigned PH_W = $clog2(max3(T_AS, E_HIGH, E_LOW) + 1);
    localparam int unsigned PC_W = $clog2(POLL_MAX + 1);

    state_t          state;
    logic            rs_q;
    logic            poll_q;
    logic [7:0]      rd;
    logic [PC_W-1:0] poll_cnt;

    logic            accept_c;
    logic            arb_go_c;
    logic            setup_end_c;
    logic            ehigh_end_c;
    logic            ehold_end_c;
    logic            repoll_c;
    logic            ph_load_c;
    logic [PH_W-1:0] ph_len_c;
    logic            ph_done_c;

    // Phase-boundary events; the timer reloads on every phase entry.
    always_comb begin
        accept_c    = req_valid && req_ready;
        arb_go_c    = (state == ARB) && bus_gnt;
        setup_end_c = (state == SETUP) && ph_done_c;
        ehigh_end_c = (state == EHIGH) && ph_done_c;
        ehold_end_c = (state == EHOLD) && ph_done_c;
        repoll_c    = ehold_end_c && poll_q && rd[BF_BIT] && (poll_cnt < PC_W'(POLL_MAX));
        ph_load_c   = arb_go_c || setup_end_c || ehigh_end_c || repoll_c;
        ph_len_c    = PH_W'(T_AS);
        if (setup_end_c) begin
            ph_len_c = PH_W'(E_HIGH);
        end else if (ehigh_end_c) begin
            ph_len_c = PH_W'(E_LOW);
        end
    end

    lcd_phase_timer #(
        .W(PH_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ph_load_c),
        .len   (ph_len_c),
        .done_c(ph_done_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
            rsp_timeout <= 1'b0;
            bus_req     <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_rw      <= 1'b0;
            lcd_e       <= 1'b0;
            rs_q        <= 1'b0;
            poll_q      <= 1'b0;
            rd          <= 8'h00;
            poll_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state     <= ARB;
                        req_ready <= 1'b0;
                        bus_req   <= 1'b1;
                        rs_q      <= req_rs;
                        poll_q    <= req_poll && (req_rs == RS_CMD);
                        poll_cnt  <= '0;
                    end
                end
                ARB: begin
                    if (arb_go_c) begin
                        state  <= SETUP;
                        lcd_rw <= 1'b1;
                        lcd_rs <= rs_q;
                    end
                end
                SETUP: begin
                    if (setup_end_c) begin
                        state <= EHIGH;
                        lcd_e <= 1'b1;
                    end
                end
                EHIGH: begin
                    if (ehigh_end_c) begin
                        state <= EHOLD;
                        lcd_e <= 1'b0;
                        rd    <= lcd_data_i;
                        if (poll_cnt != PC_W'(POLL_MAX)) begin
                            poll_cnt <= poll_cnt + PC_W'(1);
                        end
                    end
                end
                EHOLD: begin
                    // Polling keeps RW/RS asserted and the grant held between reads.
                    if (repoll_c) begin
                        state <= SETUP;
                    end else if (ehold_end_c) begin
                        state       <= DONE;
                        bus_req     <= 1'b0;
                        lcd_rw      <= 1'b0;
                        lcd_rs      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= rd;
                        rsp_timeout <= poll_q && rd[BF_BIT];
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: directed table, randomized requests vs. a read-count model, reset abort.
module tb_lcd_reader;
    import lcd_pkg::*;

    localparam int unsigned PM     = 5;
    localparam int          RD_CYC = int'(T_AS_DEF + E_HIGH_DEF + E_LOW_DEF);
    localparam int          BUDGET = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rs = 1'b0;
    logic       req_poll = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       bus_req;
    logic       bus_gnt = 1'b1;
    logic [7:0] lcd_data_i = 8'h00;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;

    int checks = 0;
    int errors = 0;

    lcd_reader #(
        .T_AS    (T_AS_DEF),
        .E_HIGH  (E_HIGH_DEF),
        .E_LOW   (E_LOW_DEF),
        .POLL_MAX(PM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs     (req_rs),
        .req_poll   (req_poll),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .lcd_data_i (lcd_data_i),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rs;
        logic        poll;
        int          g;
        int          nb;
        logic [39:0] bytes;
        logic [7:0]  exp_data;
        logic        exp_to;
        int          exp_lat;
        int          exp_pulses;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Byte the LCD returns on read n (1-based); the last listed byte repeats.
    function automatic logic [7:0] byte_at(input logic [39:0] b, input int nb, input int n);
        int idx;
        idx = (n <= nb) ? n - 1 : nb - 1;
        return b[8*idx +: 8];
    endfunction

    // Reference: keep reading while polling a busy flag, up to PM reads.
    task automatic model(input logic rs, input logic poll, input int g, input int nb,
                         input logic [39:0] bytes, output logic [7:0] d, output logic to,
                         output int n, output int lat);
        logic [7:0] b;
        logic polling;
        polling = poll && (rs == RS_CMD);
        n = 0;
        do begin
            n++;
            b = byte_at(bytes, nb, n);
        end while (polling && b[BF_BIT] && n < int'(PM));
        d   = b;
        to  = polling && b[BF_BIT];
        lat = 2 + g + n * RD_CYC;
    endtask

    task automatic run_req(input string nm, input logic rs, input logic poll, input int g,
                           input int nb, input logic [39:0] bytes, input logic [7:0] ed,
                           input logic eto, input int elat, input int epul);
        int k, pulses, width, badw, viol;
        logic prev_e, got;
        logic [7:0] held;
        k = 0; pulses = 0; width = 0; badw = 0; viol = 0; prev_e = 1'b0; got = 1'b0;
        held = rsp_data;
        req_rs = rs; req_poll = poll; req_valid = 1'b1; bus_gnt = (g == 0);
        if (!req_ready) viol++;
        while (!got && k < BUDGET) begin
            @(posedge clk); #1; k++;
            req_valid = 1'b0;
            bus_gnt = (k > g);
            if (k == 1 && req_ready) viol++;
            if (lcd_e && !prev_e) begin
                pulses++;
                width = 0;
                lcd_data_i = byte_at(bytes, nb, pulses);
            end
            if (lcd_e) begin
                width++;
                if (!lcd_rw || lcd_rs != rs) viol++;
            end else if (prev_e && width != int'(E_HIGH_DEF)) begin
                badw++;
            end
            if (k <= g + 1 && (lcd_e || lcd_rw)) viol++;
            prev_e = lcd_e;
            if (rsp_valid) begin
                got = 1'b1;
                if (bus_req || lcd_rw) viol++;
            end else begin
                if (!bus_req) viol++;
                if (rsp_data != held) viol++;
            end
        end
        chk({nm, ".done"}, int'(got), 1);
        chk({nm, ".latency"}, k, elat);
        chk({nm, ".data"}, int'(rsp_data), int'(ed));
        chk({nm, ".timeout"}, int'(rsp_timeout), int'(eto));
        chk({nm, ".pulses"}, pulses, epul);
        chk({nm, ".bad_widths"}, badw, 0);
        @(posedge clk); #1;
        if (rsp_valid || !req_ready) viol++;
        chk({nm, ".protocol"}, viol, 0);
        bus_gnt = 1'b1;
    endtask

    initial begin
        vec_t        tbl[8];
        logic        r_rs, r_poll, m_to;
        logic [7:0]  m_d;
        logic [39:0] r_bytes;
        int          r_g, r_nb, m_n, m_lat, k, width, cnt;

        tbl[0] = '{1'b0, 1'b0, 0,  1, 40'h25,         8'h25, 1'b0, 55,  1};
        tbl[1] = '{1'b0, 1'b1, 0,  4, 40'h07808080,   8'h07, 1'b0, 214, 4};
        tbl[2] = '{1'b0, 1'b1, 0,  1, 40'h8A,         8'h8A, 1'b1, 267, 5};
        tbl[3] = '{1'b1, 1'b1, 0,  1, 40'h80,         8'h80, 1'b0, 55,  1};
        tbl[4] = '{1'b0, 1'b0, 10, 1, 40'h3C,         8'h3C, 1'b0, 65,  1};
        tbl[5] = '{1'b0, 1'b0, 0,  1, 40'h80,         8'h80, 1'b0, 55,  1};
        tbl[6] = '{1'b0, 1'b1, 0,  5, 40'h7F80808080, 8'h7F, 1'b0, 267, 5};
        tbl[7] = '{1'b0, 1'b1, 3,  1, 40'h00,         8'h00, 1'b0, 58,  1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            int'({req_ready, rsp_valid, rsp_data, rsp_timeout, bus_req, lcd_e, lcd_rs, lcd_rw}),
            int'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_req($sformatf("vec%0d", i), tbl[i].rs, tbl[i].poll, tbl[i].g, tbl[i].nb,
                    tbl[i].bytes, tbl[i].exp_data, tbl[i].exp_to, tbl[i].exp_lat,
                    tbl[i].exp_pulses);
        end

        for (int i = 0; i < 24; i++) begin
            r_rs    = 1'($urandom_range(0, 1));
            r_poll  = ($urandom_range(0, 3) != 0);
            r_g     = int'($urandom_range(0, 4));
            r_nb    = int'($urandom_range(1, 5));
            r_bytes = {8'($urandom), 32'($urandom)};
            model(r_rs, r_poll, r_g, r_nb, r_bytes, m_d, m_to, m_n, m_lat);
            run_req($sformatf("rnd%0d", i), r_rs, r_poll, r_g, r_nb, r_bytes, m_d, m_to,
                    m_lat, m_n);
        end

        // Abort a polled read partway through the E pulse.
        lcd_data_i = 8'h80;
        req_rs = 1'b0; req_poll = 1'b1; req_valid = 1'b1;
        k = 0; width = 0;
        while (k < BUDGET && width < 10) begin
            @(posedge clk); #1; k++;
            req_valid = 1'b0;
            if (lcd_e) width++;
        end
        chk("abort.reach_ehigh", width, 10);
        #3 rst_n = 1'b0;
        #1;
        chk("abort.async_lines", int'({lcd_e, bus_req, req_ready, rsp_valid, lcd_rw}),
            int'(5'b00100));
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (rsp_valid || lcd_e || bus_req) cnt++;
        end
        chk("abort.no_response", cnt, 0);
        run_req("after_abort", 1'b0, 1'b0, 0, 1, 40'h25, 8'h25, 1'b0, 55, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
